// File: rtl/shift_pkg.sv
// Shared types and op codes for the universal shift register.
// Optional rotate support is selected by UNIV_SHIFT_ROTATE_EN (see shift_step).
package shift_pkg;

    localparam logic [2:0] OPC_LOAD = 3'd0;
    localparam logic [2:0] OPC_SHL  = 3'd1;
    localparam logic [2:0] OPC_SHR  = 3'd2;
    localparam logic [2:0] OPC_SRA  = 3'd3;
    localparam logic [2:0] OPC_ROL  = 3'd4;
    localparam logic [2:0] OPC_ROR  = 3'd5;

    typedef enum logic [2:0] {
        OP_LOAD = OPC_LOAD,
        OP_SHL  = OPC_SHL,
        OP_SHR  = OPC_SHR,
        OP_SRA  = OPC_SRA,
        OP_ROL  = OPC_ROL,
        OP_ROR  = OPC_ROR
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_e;

    // LOAD and the reserved codes 6-7 finish on the acceptance edge.
    function automatic logic op_is_immediate(input logic [2:0] op);
        return (op == OPC_LOAD) || (op > OPC_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit step of the shift register.
// UNIV_SHIFT_ROTATE_EN: when undefined, ROL aliases SHL and ROR aliases SHR.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] cur,
    input  logic             serial_in,
    output logic [WIDTH-1:0] nxt,
    output logic             ejected
);

    always_comb begin
        nxt     = cur;
        ejected = 1'b0;
        case (op)
`ifdef UNIV_SHIFT_ROTATE_EN
            OP_SHL: begin
                nxt     = {cur[WIDTH-2:0], serial_in};
                ejected = cur[WIDTH-1];
            end
            OP_SHR: begin
                nxt     = {serial_in, cur[WIDTH-1:1]};
                ejected = cur[0];
            end
            OP_ROL: begin
                nxt     = {cur[WIDTH-2:0], cur[WIDTH-1]};
                ejected = cur[WIDTH-1];
            end
            OP_ROR: begin
                nxt     = {cur[0], cur[WIDTH-1:1]};
                ejected = cur[0];
            end
`else
            OP_SHL, OP_ROL: begin
                nxt     = {cur[WIDTH-2:0], serial_in};
                ejected = cur[WIDTH-1];
            end
            OP_SHR, OP_ROR: begin
                nxt     = {serial_in, cur[WIDTH-1:1]};
                ejected = cur[0];
            end
`endif
            OP_SRA: begin
                nxt     = {cur[WIDTH-1], cur[WIDTH-1:1]};
                ejected = cur[0];
            end
            default: begin
                nxt     = cur;
                ejected = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: accepts one request, performs 'amount' single-bit steps,
// then holds the result until consumed. Rotate ops depend on UNIV_SHIFT_ROTATE_EN.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    input  logic             serial_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic             busy
);

    shift_state_e     state_reg, state_next;
    logic [WIDTH-1:0] data_reg;
    logic [AMT_W-1:0] cnt_reg;
    logic [2:0]       op_reg;
    logic             sout_reg;
    logic [WIDTH-1:0] step_data;
    logic             step_out;
    logic             accept;

    assign accept = in_valid && (state_reg == ST_IDLE);

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op        (op_reg),
        .cur       (data_reg),
        .serial_in (serial_in),
        .nxt       (step_data),
        .ejected   (step_out)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (op_is_immediate(op) || (amount == '0))
                        state_next = ST_DONE;
                    else
                        state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_reg == AMT_W'(1))
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            data_reg  <= '0;
            cnt_reg   <= '0;
            op_reg    <= OPC_LOAD;
            sout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        data_reg <= data_in;
                        cnt_reg  <= amount;
                        op_reg   <= op;
                        sout_reg <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    data_reg <= step_data;
                    sout_reg <= step_out;
                    cnt_reg  <= cnt_reg - AMT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state_reg == ST_IDLE);
    assign out_valid  = (state_reg == ST_DONE);
    assign busy       = (state_reg != ST_IDLE);
    assign data_out   = data_reg;
    assign serial_out = sout_reg;

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter AMT_W, default $clog2(WIDTH), width of the shift-amount field.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  3  operation: 0 LOAD, 1 SHL, 2 SHR, 3 SRA, 4 ROL, 5 ROR; 6-7 reserved.
REQ-008 amount  input  AMT_W  number of single-bit steps, 0..WIDTH-1.
REQ-009 data_in  input  WIDTH  operand, captured on acceptance.
REQ-010 serial_in  input  1  fill bit for SHL/SHR; sampled on every step.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 data_out  output  WIDTH  register contents.
REQ-014 serial_out  output  1  bit ejected by the most recent step.
REQ-015 busy  output  1  high whenever not IDLE.

Function
REQ-016 FSM states: IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 Acceptance = in_valid && in_ready at a rising edge: reg <= data_in, cnt <= amount, serial_out <= 0, op latched.
REQ-018 On acceptance, next state = DONE if op is LOAD, op is reserved, or amount==0; otherwise SHIFT.
REQ-019 In SHIFT, each cycle: reg <= one-bit step of latched op, cnt <= cnt-1; transition to DONE when cnt==1.
REQ-020 Latency: out_valid rises exactly max(amount,1) cycles after the acceptance edge; LOAD/reserved ops take 1 cycle.
REQ-021 Step rules: SHL {reg[W-2:0],serial_in}, out reg[W-1]; SHR {serial_in,reg[W-1:1]}, out reg[0]; SRA {reg[W-1],reg[W-1:1]}, out reg[0]; ROL {reg[W-2:0],reg[W-1]}, out reg[W-1]; ROR {reg[0],reg[W-1:1]}, out reg[0].
REQ-022 DONE holds data_out and serial_out stable until out_ready; out_valid && out_ready -> IDLE next cycle.
REQ-023 in_ready is low in SHIFT and DONE; a request presented then is not accepted and must be held by the source.
REQ-024 data_out always equals the internal register; it is not masked outside DONE.
REQ-025 amount values >= WIDTH are out of range; the block performs amount steps regardless (no saturation).

Reset
REQ-026 rst_n low: state IDLE, reg 0, cnt 0, serial_out 0, in_ready 1, out_valid 0, busy 0, effective immediately regardless of clk.
REQ-027 Reset asserted mid-SHIFT or in DONE aborts the operation; no result is delivered.

Configuration
REQ-028 Macro UNIV_SHIFT_ROTATE_EN defined: ROL/ROR behave per REQ-021.
REQ-029 Macro UNIV_SHIFT_ROTATE_EN undefined: op 4 behaves exactly as SHL and op 5 exactly as SHR; no rotate logic is synthesised.

Structure
REQ-030 Package shift_pkg holds the op enum (shift_op_e, 3 bits), the FSM state enum, and op code constants.
REQ-031 Sub-module shift_step: combinational single-bit step (op, reg, serial_in -> next reg, ejected bit), WIDTH-parametrised.

Verification (WIDTH=8, macro defined unless stated)
REQ-032 SHL, data_in 0x81, amount 3, serial_in 0 -> out_valid 3 cycles after accept, data_out 0x08, serial_out 0.
REQ-033 SHR, data_in 0x00, amount 3, serial_in 1 -> data_out 0xE0; SRA, data_in 0x90, amount 2 -> data_out 0xE4, serial_out 0.
REQ-034 ROR 0x81 by 1 -> 0xC0, serial_out 1; same stimulus with macro undefined, serial_in 0 -> 0x40, serial_out 1.
REQ-035 LOAD 0x5A and SHL amount 0 -> out_valid 1 cycle after accept, data_out 0x5A; out_ready held low 5 cycles -> outputs stable, in_ready low throughout.
REQ-036 rst_n pulsed low during cycle 2 of SHL 0xFF by 5 -> immediate IDLE, data_out 0x00, out_valid never asserted; next request processes normally.
